digit_mask_gen: RTL and testbench

//   Sits between shift_reg and segment_controller. Tracks how many hex digits

---
 rtl/digit_mask_gen.sv | 140 ++++++++++++++
 tb/tb_digit_mask_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_mask_gen.sv
// -----------------------------------------------------------------------------
// digit_mask_gen
//
// Purpose:
//   Sits between shift_reg and segment_controller. It counts the hex digits
//   entered since the last clear and registers the NUMB word. It also drives
//   a per-digit enable mask, so digits that have not been entered stay dark.
//   As an option, it blinks the newest digit (digit 0) as an entry cursor.
//
// Optional feature:
//   CURSOR_BLINK_EN - when defined, digit 0 blinks while
//   1 <= digit_count < DIGITS. When undefined, no prescaler or phase logic
//   is built and digit_en is the plain base mask.
//
// Parameters:
//   DIGITS     number of display digits (nibbles in numb_in)
//   BLINK_DIV  clk cycles per cursor half-period (>= 2)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   clr          in   1-cycle clear pulse (clears the digit count)
//   enter        in   1-cycle enter pulse (adds one digit, saturating)
//   numb_in      in   NUMB word from shift_reg; digit 0 = bits [3:0] = newest
//   numb_out     out  registered copy of numb_in (1-cycle latency)
//   digit_en     out  per-digit enable; bit i gates digit i
//   digit_count  out  number of digits entered, 0..DIGITS
//   full         out  high when digit_count == DIGITS
// -----------------------------------------------------------------------------
module digit_mask_gen #(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          enter,
    input  logic [4*DIGITS-1:0]           numb_in,
    output logic [4*DIGITS-1:0]           numb_out,
    output logic [DIGITS-1:0]             digit_en,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count,
    output logic                          full
);

    localparam int                CNT_W   = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIGITS);

    logic [4*DIGITS-1:0] numb_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS-1:0]   en_q, en_d;

    // Digit 0 stays lit at count 0, so an empty display still shows "0".
    function automatic logic [DIGITS-1:0] base_mask(input logic [CNT_W-1:0] cnt);
        logic [DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < DIGITS; i++) begin
            m[i] = (i == 0) || (i < int'(cnt));
        end
        return m;
    endfunction

    // clr wins over enter; enter saturates at DIGITS because shift_reg simply
    // drops its oldest nibble once full.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (enter && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int                 PRE_W   = $clog2(BLINK_DIV);
    localparam logic [PRE_W-1:0]   PRE_TOP = PRE_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             phase_q, phase_d;
    logic             cursor_live;

    // Any key restarts the half-period with the cursor visible. This also
    // covers enter while full, so every keypress gives immediate feedback.
    always_comb begin
        pre_d   = pre_q;
        phase_d = phase_q;
        if (clr || enter) begin
            pre_d   = '0;
            phase_d = 1'b1;
        end else if (pre_q == PRE_TOP) begin
            pre_d   = '0;
            phase_d = ~phase_q;
        end else begin
            pre_d   = pre_q + 1'b1;
        end
    end

    // The next-state count and phase are used so the mask moves on the same
    // edge as digit_count and is never a cycle stale.
    assign cursor_live = (cnt_d != '0) && (cnt_d != CNT_MAX);

    always_comb begin
        en_d = base_mask(cnt_d);
        if (cursor_live) begin
            en_d[0] = en_d[0] & phase_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
        end
    end
`else
    always_comb begin
        en_d = base_mask(cnt_d);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            numb_q <= '0;
            cnt_q  <= '0;
            en_q   <= DIGITS'(1);
        end else begin
            numb_q <= numb_in;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
        end
    end

    assign numb_out    = numb_q;
    assign digit_count = cnt_q;
    assign digit_en    = en_q;
    assign full        = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_digit_mask_gen.sv
module tb_digit_mask_gen;

    localparam int DIGITS    = 8;
    localparam int BLINK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        enter = 1'b0;
    logic [31:0] numb_in = '0;
    logic [31:0] numb_out;
    logic [7:0]  digit_en;
    logic [3:0]  digit_count;
    logic        full;

    int tests  = 0;
    int failed = 0;

    // Reference state: digits entered, edges since the last key or reset,
    // and the numb value most recently captured.
    int          m_cnt   = 0;
    int          m_since = 0;
    logic [31:0] m_numb  = '0;

    digit_mask_gen #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst(rst), .clr(clr), .enter(enter),
        .numb_in(numb_in), .numb_out(numb_out), .digit_en(digit_en),
        .digit_count(digit_count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c;
        logic        e;
        logic [31:0] n;
        int          cnt;
        logic [7:0]  en;
        logic        fl;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected mask from the count, with the cursor hidden during the odd
    // half-periods counted from the last key.
    function automatic logic [7:0] model_en();
        logic [7:0] m;
        if (m_cnt == 0) m = 8'h01;
        else            m = 8'((1 << m_cnt) - 1);
`ifdef CURSOR_BLINK_EN
        if (m_cnt > 0 && m_cnt < DIGITS && ((m_since / BLINK_DIV) % 2) == 1)
            m[0] = 1'b0;
`endif
        return m;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(digit_count), 32'(m_cnt));
        chk({tag, ".en"},    32'(digit_en),    32'(model_en()));
        chk({tag, ".full"},  32'(full),        32'(m_cnt == DIGITS));
        chk({tag, ".numb"},  numb_out,         m_numb);
    endtask

    task automatic tick(input logic c, input logic e, input logic [31:0] n);
        clr = c; enter = e; numb_in = n;
        @(posedge clk);
        if (c) begin
            m_cnt = 0; m_since = 0;
        end else if (e) begin
            if (m_cnt < DIGITS) m_cnt++;
            m_since = 0;
        end else begin
            m_since++;
        end
        m_numb = n;
        #1;
        clr = 1'b0; enter = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_cnt = 0; m_since = 0; m_numb = '0;
        chk("rst.count", 32'(digit_count), 32'd0);
        chk("rst.en",    32'(digit_en),    32'h01);
        chk("rst.full",  32'(full),        32'd0);
        chk("rst.numb",  numb_out,         32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_000A, 1, 8'h01, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_00AB, 2, 8'h03, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0ABC, 3, 8'h07, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 0, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0001, 1, 8'h01, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0012, 2, 8'h03, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0123, 3, 8'h07, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_1234, 4, 8'h0F, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0001_2345, 5, 8'h1F, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0012_3456, 6, 8'h3F, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0123_4567, 7, 8'h7F, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h1234_5678, 8, 8'hFF, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h2345_6789, 8, 8'hFF, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 0, 8'h01, 1'b0};

        // Initial reset state
        repeat (2) @(posedge clk);
        #1;
        chk("init.count", 32'(digit_count), 32'd0);
        chk("init.en",    32'(digit_en),    32'h01);
        chk("init.full",  32'(full),        32'd0);
        chk("init.numb",  numb_out,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: every row has a key, so the cursor is visible.
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].c, vecs[i].e, vecs[i].n);
            chk($sformatf("vec%0d.count", i), 32'(digit_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d.en", i),    32'(digit_en),    32'(vecs[i].en));
            chk($sformatf("vec%0d.full", i),  32'(full),        32'(vecs[i].fl));
            chk($sformatf("vec%0d.numb", i),  numb_out,         vecs[i].n);
        end

        // Three enters spaced 10 cycles apart
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 1'b1, 32'(k));
            chk("sp.en_after_enter", 32'(digit_en), 32'((1 << k) - 1));
            for (int j = 0; j < 9; j++) begin
                tick(1'b0, 1'b0, 32'(k));
                check_model("sp");
            end
        end
        chk("sp.count3", 32'(digit_count), 32'd3);

        // Ten enters saturate, then full holds steady
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 32'hCAFE_0000 + 32'(k));
        for (int j = 0; j < 20; j++) begin
            tick(1'b0, 1'b0, 32'h5555_AAAA);
            chk("sat.en",    32'(digit_en),    32'hFF);
            chk("sat.full",  32'(full),        32'd1);
            chk("sat.count", 32'(digit_count), 32'd8);
        end

        // Reset while full
        do_reset();

        // clr together with enter at count 5
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 32'h0);
        chk("ce.pre", 32'(digit_count), 32'd5);
        tick(1'b1, 1'b1, 32'h0);
        chk("ce.count", 32'(digit_count), 32'd0);
        chk("ce.en",    32'(digit_en),    32'h01);

        // Idle at count 2, then enter during a dark-cursor half-period
        tick(1'b0, 1'b1, 32'h0);
        tick(1'b0, 1'b1, 32'h0);
        for (int j = 1; j <= 20; j++) begin
            tick(1'b0, 1'b0, 32'h0);
            check_model("blink");
`ifdef CURSOR_BLINK_EN
            chk("blink.pat", 32'(digit_en), (((j / 4) % 2) == 1) ? 32'h02 : 32'h03);
`else
            chk("blink.steady", 32'(digit_en), 32'h03);
`endif
        end
        tick(1'b0, 1'b1, 32'h0);
        chk("blink.enter", 32'(digit_en), 32'h07);

        // numb_out follows numb_in one edge later
        tick(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        numb_in = 32'h0000_00A5;
        #1;
        chk("numb.before", numb_out, 32'h0);
        tick(1'b0, 1'b0, 32'h0000_00A5);
        chk("numb.after", numb_out, 32'h0000_00A5);

        // Randomized traffic against the model, with one mid-run reset
        for (int r = 0; r < 400; r++) begin
            if (r == 200) do_reset();
            tick($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom);
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
